// File: rtl/mem_bram_ctrl.sv
// Word-organised SRAM controller behind the MPU memory port: pipelined reads, lane writes,
// out-of-range flagging and MPU table-window write watch. Optional lane parity under MEM_PARITY_EN.
module mem_bram_ctrl #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned TBL_BASE   = 3072,
  parameter int unsigned TBL_WORDS  = 81
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [3:0]            mem_wen,
  input  logic [21:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid,
  output logic                  oob_err,
  output logic                  tbl_mod,
  output logic [6:0]            tbl_mod_idx,
  output logic                  tbl_dirty,
  input  logic                  tbl_clr,
  output logic [15:0]           wr_cnt,
  input  logic                  par_inject,
  output logic                  par_err
);

  localparam int unsigned AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned TBL_LO = TBL_BASE / 4;
  localparam int unsigned TBL_HI = TBL_LO + TBL_WORDS;
  localparam logic [20:0] MEM_LIM  = 21'(MEM_WORDS);
  localparam logic [20:0] TBL_LO_W = 21'(TBL_LO);
  localparam logic [20:0] TBL_HI_W = 21'(TBL_HI);

  if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_lat
    $error("mem_bram_ctrl: READ_LAT must be 1..3");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("mem_bram_ctrl: only DATA_WIDTH=32 is supported");
  end

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] r_data [READ_LAT];
  logic [READ_LAT-1:0]   r_vld;
  logic [READ_LAT-1:0]   r_perr;
  logic                  r_oob;
  logic                  r_mod;
  logic [6:0]            r_mod_idx;
  logic                  r_dirty;
  logic [15:0]           r_cnt;

  logic [19:0]           w_idx;
  logic [AW-1:0]         w_aidx;
  logic                  w_in_range;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_tbl_wr;
  logic [DATA_WIDTH-1:0] w_rdword;
  logic                  w_pmis;
  logic                  w_unused;

  assign w_idx      = mem_addr[21:2];
  assign w_aidx     = w_idx[AW-1:0];
  assign w_in_range = {1'b0, w_idx} < MEM_LIM;
  assign w_rd       = (mem_wen == 4'h0);
  assign w_wr       = resetn && !w_rd && w_in_range;
  assign w_tbl_wr   = w_wr && ({1'b0, w_idx} >= TBL_LO_W) && ({1'b0, w_idx} < TBL_HI_W);
  assign w_rdword   = w_in_range ? r_mem[w_aidx] : '0;

  // Storage array: no reset, contents survive resetn.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_wen[l]) r_mem[w_aidx][8*l +: 8] <= mem_wdata[8*l +: 8];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [3:0] r_par [MEM_WORDS];

  // Even parity per lane; par_inject corrupts only the lane-0 bit.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_wen[l]) r_par[w_aidx][l] <= (^mem_wdata[8*l +: 8]) ^ (par_inject && (l == 0));
      end
    end
  end

  always_comb begin
    w_pmis = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if ((^w_rdword[8*l +: 8]) != r_par[w_aidx][l]) w_pmis = 1'b1;
    end
    w_pmis = w_pmis && w_in_range;
  end

  assign par_err  = r_perr[READ_LAT-1];
  assign w_unused = ^mem_addr[1:0];
`else
  assign w_pmis   = 1'b0;
  assign par_err  = 1'b0;
  assign w_unused = ^{par_inject, mem_addr[1:0], r_perr};
`endif

  // Read pipeline: data only advances with a valid read so mem_rdata holds between reads.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld  <= '0;
      r_perr <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) r_data[i] <= '0;
    end else begin
      r_vld[0]  <= w_rd;
      r_perr[0] <= w_rd && w_pmis;
      if (w_rd) r_data[0] <= w_rdword;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_perr[i] <= r_perr[i-1];
        if (r_vld[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  // Status: range error, table watch (set beats clear) and saturating write count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_oob     <= 1'b0;
      r_mod     <= 1'b0;
      r_mod_idx <= 7'd0;
      r_dirty   <= 1'b0;
      r_cnt     <= 16'd0;
    end else begin
      r_oob   <= !w_in_range;
      r_mod   <= w_tbl_wr;
      r_dirty <= w_tbl_wr || (r_dirty && !tbl_clr);
      if (w_tbl_wr) r_mod_idx <= 7'(w_idx - 20'(TBL_LO));
      if (w_wr && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign mem_rdata   = r_data[READ_LAT-1];
  assign mem_rvalid  = r_vld[READ_LAT-1];
  assign oob_err     = r_oob;
  assign tbl_mod     = r_mod;
  assign tbl_mod_idx = r_mod_idx;
  assign tbl_dirty   = r_dirty;
  assign wr_cnt      = r_cnt;

endmodule
